fp_to_int: RTL and testbench

- Sequential converter from the team's small floating-point format (sign, 4-bit exponent, 8-bit normalized fraction) to a signed two's-complement integer.
- Consumes the results produced by the FP add datapath, and is the read-out end of that number format toward integer consumers (display, counters, control logic).
- Shifts one bit per cycle, so area stays small.
- Uses valid/ready handshakes on both sides.

---
 rtl/fp_to_int_if.sv | 32 +++
 rtl/fp_to_int.sv | 104 ++++++++++
 tb/tb_fp_to_int.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_to_int_if.sv
// fp_to_int_if: handshake and data bundle for the float-to-integer converter.
//   in_valid/in_ready  operand handshake
//   in_sign/in_exp/in_frac  operand fields (sign, biased exponent, fraction)
//   out_valid/out_ready  result handshake
//   out_int/out_inexact  signed truncated result and lost-bits flag
// modport master: producer of operands and consumer of results (e.g. a bench)
// modport slave:  the converter itself
interface fp_to_int_if #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8,
    parameter int INT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W-1:0] in_frac;
    logic              out_valid;
    logic              out_ready;
    logic [INT_W-1:0]  out_int;
    logic              out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_frac, out_ready,
        input  in_ready, out_valid, out_int, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_frac, out_ready,
        output in_ready, out_valid, out_int, out_inexact
    );
endinterface

// File: rtl/fp_to_int.sv
// fp_to_int: sequential converter from the small float format
// (sign, EXP_W-bit biased exponent, FRAC_W-bit fraction) to a signed
// INT_W-bit two's-complement integer, truncated toward zero.
// The magnitude is shifted one bit per clock, so latency is
// |exp - BIAS| + 1 cycles from accept to out_valid.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      fp_to_int_if.slave: operand handshake in, result handshake out
module fp_to_int #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8,
    parameter int BIAS   = 8,
    parameter int INT_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    fp_to_int_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [EXP_W:0] BIAS_EXT = (EXP_W+1)'(BIAS);
    localparam logic [EXP_W:0] CNT_ONE  = (EXP_W+1)'(1);

    state_t             state_reg;
    logic [INT_W-1:0]   mag_reg;
    logic               sign_reg;
    logic               left_reg;
    logic [EXP_W:0]     cnt_reg;
    logic               sticky_reg;
    logic [INT_W-1:0]   out_int_reg;
    logic               out_inexact_reg;
    logic               out_valid_reg;

    // Shift distance and direction of the incoming operand, one bit wider
    // than the exponent so the subtraction cannot wrap.
    logic [EXP_W:0]     exp_ext;
    logic               exp_ge_bias;
    logic [EXP_W:0]     cnt_in;

    assign exp_ext     = {1'b0, bus.in_exp};
    assign exp_ge_bias = (exp_ext >= BIAS_EXT);
    assign cnt_in      = exp_ge_bias ? (exp_ext - BIAS_EXT) : (BIAS_EXT - exp_ext);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            mag_reg         <= '0;
            sign_reg        <= 1'b0;
            left_reg        <= 1'b0;
            cnt_reg         <= '0;
            sticky_reg      <= 1'b0;
            out_int_reg     <= '0;
            out_inexact_reg <= 1'b0;
            out_valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_reg    <= INT_W'(bus.in_frac);
                        sign_reg   <= bus.in_sign;
                        sticky_reg <= 1'b0;
                        left_reg   <= exp_ge_bias;
                        cnt_reg    <= cnt_in;
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_reg != '0) begin
                        if (left_reg) begin
                            mag_reg <= mag_reg << 1;
                        end else begin
                            mag_reg    <= mag_reg >> 1;
                            // Any 1 falling off the bottom makes the result inexact.
                            sticky_reg <= sticky_reg | mag_reg[0];
                        end
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end else begin
                        // Negating a zero magnitude yields zero, so no negative zero.
                        out_int_reg     <= sign_reg ? (~mag_reg + INT_W'(1)) : mag_reg;
                        out_inexact_reg <= sticky_reg;
                        out_valid_reg   <= 1'b1;
                        state_reg       <= DONE;
                    end
                end
                DONE: begin
                    // Result held until taken; out_int keeps its value afterwards.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (state_reg == IDLE);
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_int     = out_int_reg;
    assign bus.out_inexact = out_inexact_reg;
endmodule

// File: tb/tb_fp_to_int.sv
module tb_fp_to_int;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;
    localparam int BIAS   = 8;
    localparam int INT_W  = 16;

    typedef struct {
        logic [INT_W-1:0] val;
        logic             inexact;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb_q[$];
    logic [INT_W-1:0] last_val;
    logic             last_inexact;

    fp_to_int_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .INT_W(INT_W)) bus ();

    fp_to_int #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .BIAS(BIAS), .INT_W(INT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // Reference: frac * 2^(exp-BIAS), truncated toward zero.
    function automatic exp_t model(input logic s, input int e, input int f);
        exp_t r;
        int   m;
        int   sh;
        r.inexact = 1'b0;
        if (e >= BIAS) begin
            m = f * (1 << (e - BIAS));
        end else begin
            sh = BIAS - e;
            m  = f / (1 << sh);
            r.inexact = ((f % (1 << sh)) != 0);
        end
        if (s) m = -m;
        r.val = m[INT_W-1:0];
        r.lat = ((e >= BIAS) ? (e - BIAS) : (BIAS - e)) + 1;
        return r;
    endfunction

    task automatic drive_accept(input logic s, input int e, input int f);
        logic rdy;
        int   waited;
        waited = 0;
        bus.in_sign  = s;
        bus.in_exp   = e[EXP_W-1:0];
        bus.in_frac  = f[FRAC_W-1:0];
        bus.in_valid = 1'b1;
        forever begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
        sb_q.push_back(model(s, e, f));
        check("ready_low_after_accept", 32'(bus.in_ready), 32'd0);
        $display("accept sign=%0d exp=%0d frac=%02h", s, e, f);
    endtask

    task automatic wait_result();
        int   edges;
        logic ready_seen;
        exp_t ex;
        edges = 0;
        ready_seen = 1'b0;
        while (!bus.out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.in_ready && !bus.out_valid) ready_seen = 1'b1;
        end
        check("out_valid_seen", 32'(bus.out_valid), 32'd1);
        check("ready_low_while_busy", 32'(ready_seen), 32'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            ex = sb_q.pop_front();
            check("latency", 32'(edges), 32'(ex.lat));
            check("out_int", 32'(bus.out_int), 32'(ex.val));
            check("out_inexact", 32'(bus.out_inexact), 32'(ex.inexact));
            last_val     = ex.val;
            last_inexact = ex.inexact;
            $display("result out_int=%04h inexact=%0d edges=%0d", bus.out_int, bus.out_inexact, edges);
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("valid_clear_on_take", 32'(bus.out_valid), 32'd0);
        check("ready_after_take", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic convert(input logic s, input int e, input int f);
        drive_accept(s, e, f);
        wait_result();
        release_result();
    endtask

    initial begin
        logic stale;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_frac   = '0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_int", 32'(bus.out_int), 32'd0);
        check("rst_out_inexact", 32'(bus.out_inexact), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        convert(1'b0, 8, 8'h80);     // unity exponent -> 128
        convert(1'b0, 15, 8'hFF);    // max magnitude -> 32640
        convert(1'b1, 5, 8'hB4);     // -22, inexact
        convert(1'b0, 0, 8'hFF);     // everything shifted out -> 0, inexact
        convert(1'b1, 3, 8'h00);     // zero with sign -> 0
        convert(1'b0, 10, 8'h05);    // non-normalized -> 20
        convert(1'b1, 12, 8'h81);    // -2064

        // Backpressure with a second operand waiting.
        drive_accept(1'b0, 9, 8'h90);
        wait_result();
        bus.in_sign  = 1'b1;
        bus.in_exp   = 4'd7;
        bus.in_frac  = 8'h03;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_int", 32'(bus.out_int), 32'(last_val));
            check("bp_out_inexact", 32'(bus.out_inexact), 32'(last_inexact));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        release_result();
        drive_accept(1'b1, 7, 8'h03);  // -1, inexact
        wait_result();
        release_result();

        // Asynchronous reset during the third shift cycle.
        drive_accept(1'b0, 0, 8'hAA);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_int", 32'(bus.out_int), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_inexact", 32'(bus.out_inexact), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale = 1'b1;
        end
        check("no_stale_valid", 32'(stale), 32'd0);
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);
        convert(1'b1, 11, 8'hC3);    // -1560

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
